adder_result_recover: RTL

//  Receiving end of the adder datapath: takes an adder result {Cout,Sum} and operand B,

---
 rtl/adder_result_recover_if.sv | 27 ++
 rtl/adder_result_recover.sv | 128 ++++++++++++
 2 files changed

// File: rtl/adder_result_recover_if.sv
// Handshake bundle for the adder result recovery block: input side carries
// {Cout,Sum} and B, output side returns the recovered A and its range flag.
interface adder_result_recover_if #(
  parameter int unsigned n = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] Sum;
  logic         Cout;
  logic [n-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] A;
  logic         A_err;

  // Producer/consumer side of the block
  modport master (
    output in_valid, Sum, Cout, B, out_ready,
    input  in_ready, out_valid, A, A_err
  );

  // The recovery block itself
  modport slave (
    input  in_valid, Sum, Cout, B, out_ready,
    output in_ready, out_valid, A, A_err
  );
endinterface

// File: rtl/adder_result_recover.sv
// Recovers operand A = {Cout,Sum} - B with a bit-serial borrow chain, LSB first,
// and flags differences that underflow or do not fit in n bits.
module adder_result_recover #(
  parameter int unsigned n = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_result_recover_if.slave bus
);

  localparam int unsigned CW = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_nxt;
  logic [n:0]      m_q, m_nxt;
  logic [n:0]      s_q, s_nxt;
  logic [n:0]      r_q, r_nxt;
  logic            borrow_q, borrow_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [n-1:0]    a_q, a_nxt;
  logic            a_err_q, a_err_nxt;
  logic            out_valid_q, out_valid_nxt;
  logic            in_ready_q, in_ready_nxt;

  logic            d_c;
  logic            borrow_c;
  logic [n:0]      r_shift_c;

  // One full-subtractor slice on the current LSBs
  always_comb begin
    d_c       = m_q[0] ^ s_q[0] ^ borrow_q;
    borrow_c  = (~m_q[0] & s_q[0]) | (~(m_q[0] ^ s_q[0]) & borrow_q);
    r_shift_c = {d_c, r_q[n:1]};
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt     = state_q;
    m_nxt         = m_q;
    s_nxt         = s_q;
    r_nxt         = r_q;
    borrow_nxt    = borrow_q;
    cnt_nxt       = cnt_q;
    a_nxt         = a_q;
    a_err_nxt     = a_err_q;
    out_valid_nxt = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          m_nxt      = {bus.Cout, bus.Sum};
          s_nxt      = {1'b0, bus.B};
          borrow_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = SHIFT;
        end
      end

      SHIFT: begin
        m_nxt      = {1'b0, m_q[n:1]};
        s_nxt      = {1'b0, s_q[n:1]};
        r_nxt      = r_shift_c;
        borrow_nxt = borrow_c;
        cnt_nxt    = cnt_q + CW'(1);
        // Bit n of the difference is the overflow indicator; a final borrow means underflow
        if (cnt_q == CW'(n)) begin
          cnt_nxt       = cnt_q;
          a_nxt         = r_shift_c[n-1:0];
          a_err_nxt     = borrow_c | r_shift_c[n];
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        out_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase

    in_ready_nxt = (state_nxt == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      s_q         <= '0;
      r_q         <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      a_err_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      m_q         <= m_nxt;
      s_q         <= s_nxt;
      r_q         <= r_nxt;
      borrow_q    <= borrow_nxt;
      cnt_q       <= cnt_nxt;
      a_q         <= a_nxt;
      a_err_q     <= a_err_nxt;
      out_valid_q <= out_valid_nxt;
      in_ready_q  <= in_ready_nxt;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.A         = a_q;
  assign bus.A_err     = a_err_q;

endmodule
